id_ex_stage: RTL

// - ID/EX pipeline register of the 5-stage MIPS core. Captures register-file operands, decoded controls and immediate each cycle and presents them to EX.
// - Adds WB->ID write-through bypass, load-use hazard detection with bubble insertion, branch flush, downstream hold and a saturating bubble counter.

---
 rtl/mips_pipe_pkg.sv | 37 +++
 rtl/id_ex_stage_load_use_detector.sv | 30 +++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared widths, ALU operation encodings and control-bundle layout for the
// 5-stage MIPS pipeline.
package mips_pipe_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALUOP_W    = 4;
  localparam int DEF_CNT_W      = 16;

  localparam logic [DEF_REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [DEF_ALUOP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  // Bit positions inside the single-bit control bundle carried ID -> EX.
  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_READ   = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;
  localparam int CTL_ALU_SRC    = 4;
  localparam int CTL_W          = 5;

  typedef logic [CTL_W-1:0] ctl_t;

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID;
// purely combinational.
module load_use_detector
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  // A load into $0 never produces a value anyone can depend on.
  assign dst_nonzero = (ex_dst != REG_ADDR_W'(REG_ZERO));
  assign rs_match    = (ex_dst == id_rs);
  assign rt_match    = id_uses_rt && (ex_dst == id_rt);

  assign load_use = ex_valid && ex_mem_read && dst_nonzero && id_valid &&
                    (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: WB write-through bypass, load-use bubble insertion,
// branch flush, downstream hold and a saturating bubble counter.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALUOP_W    = DEF_ALUOP_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic [DATA_W-1:0]     id_rdata_a,
  input  logic [DATA_W-1:0]     id_rdata_b,
  input  logic [15:0]           id_imm16,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_flush,
  input  logic                  ex_hold,
  output logic                  stall_o,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic                  load_use;
  logic                  take_bubble;
  logic                  take_load;
  logic                  count_bubble;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     imm_ext;
  logic [REG_ADDR_W-1:0] dst_sel;
  ctl_t                  ctl_in;
  ctl_t                  ctl_q;
  logic [ALUOP_W-1:0]    alu_op_in;

  load_use_detector #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use (
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_mem_read),
    .ex_dst     (ex_dst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // A flush squashes whatever IF/ID holds, so there is nothing left to freeze.
  assign stall_o = !ex_flush && (ex_hold || load_use);

  assign take_bubble  = ex_flush || (!ex_hold && load_use);
  assign take_load    = !ex_flush && !ex_hold && !load_use;
  assign count_bubble = !ex_flush && !ex_hold && load_use;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    op_a = id_rdata_a;
    if (id_rs == REG_ADDR_W'(REG_ZERO)) begin
      op_a = '0;
    end else if (wb_reg_write && (wb_rd == id_rs) && (wb_rd != REG_ADDR_W'(REG_ZERO))) begin
      op_a = wb_data;
    end
  end

  always_comb begin
    op_b = id_rdata_b;
    if (id_rt == REG_ADDR_W'(REG_ZERO)) begin
      op_b = '0;
    end else if (wb_reg_write && (wb_rd == id_rt) && (wb_rd != REG_ADDR_W'(REG_ZERO))) begin
      op_b = wb_data;
    end
  end

  always_comb begin
    ctl_in                 = '0;
    ctl_in[CTL_REG_WRITE]  = id_reg_write;
    ctl_in[CTL_MEM_READ]   = id_mem_read;
    ctl_in[CTL_MEM_WRITE]  = id_mem_write;
    ctl_in[CTL_MEM_TO_REG] = id_mem_to_reg;
    ctl_in[CTL_ALU_SRC]    = id_alu_src;
    if (!id_valid) begin
      ctl_in = '0;
    end
  end

  assign alu_op_in = id_valid ? id_alu_op : '0;
  assign imm_ext   = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
  assign dst_sel   = id_reg_dst ? id_rd : id_rt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || take_bubble) begin
      ex_valid  <= 1'b0;
      ctl_q     <= '0;
      ex_alu_op <= ALUOP_W'(ALU_ADD);
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      ex_pc4    <= '0;
    end else if (take_load) begin
      ex_valid  <= id_valid;
      ctl_q     <= ctl_in;
      ex_alu_op <= alu_op_in;
      ex_a      <= op_a;
      ex_b      <= op_b;
      ex_imm    <= imm_ext;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_dst    <= dst_sel;
      ex_pc4    <= id_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (count_bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_reg_write  = ctl_q[CTL_REG_WRITE];
  assign ex_mem_read   = ctl_q[CTL_MEM_READ];
  assign ex_mem_write  = ctl_q[CTL_MEM_WRITE];
  assign ex_mem_to_reg = ctl_q[CTL_MEM_TO_REG];
  assign ex_alu_src    = ctl_q[CTL_ALU_SRC];

endmodule
